// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time instruction-memory loader. Receives a byte stream made
//            of a 16-bit little-endian word count N followed by 4*N bytes
//            (each word little-endian). Each assembled word is written to the
//            instruction memory at consecutive word addresses starting at 0.
//            The processor is held in reset until the whole image is written.
// Ports    : clock      - single clock, rising edge
//            reset      - asynchronous active-high reset
//            in_valid   - in_data carries a byte
//            in_data    - image byte stream
//            in_ready   - a byte is accepted this cycle if in_valid is high
//            mem_wren   - one-cycle instruction-memory write strobe
//            mem_addr   - instruction-memory word address
//            mem_data   - instruction-memory write data
//            cpu_reset  - processor reset, released only after a good load
//            done       - load completed successfully
//            error      - header rejected (word count too large)
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [7:0]            r_cnt_lo;
  logic [15:0]           r_n;
  // One bit wider than the address so the post-write increment after the
  // final word at MAX_WORDS-1 never folds back to 0.
  logic [ADDR_WIDTH:0]   r_idx;
  logic [1:0]            r_bcnt;
  logic [31:0]           r_asm;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_data;

  logic                  w_accept;
  logic [15:0]           w_hdr_n;
  logic [ADDR_WIDTH:0]   w_idx_inc;
  logic                  w_last;
  logic                  w_too_big;
  logic [31:0]           w_word;

  assign w_accept  = in_valid & in_ready;
  assign w_hdr_n   = {in_data, r_cnt_lo};
  assign w_idx_inc = r_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_last    = (32'(w_idx_inc) == 32'(r_n));
  assign w_too_big = (32'(w_hdr_n) > 32'(MAX_WORDS));
  // New byte enters at the top, so the first byte of a word ends in [7:0].
  assign w_word    = {in_data, r_asm[31:8]};

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_HDR_LO;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mem_wren  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (r_state)
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (w_accept) w_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (w_too_big)          w_next = S_ERR;
          else if (w_hdr_n == 0)  w_next = S_DONE;
          else                    w_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (w_accept && (r_bcnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_wren = 1'b1;
        w_next   = w_last ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        w_next = S_HDR_LO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: header capture, word assembly, write address/data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_lo   <= 8'd0;
      r_n        <= 16'd0;
      r_idx      <= '0;
      r_bcnt     <= 2'd0;
      r_asm      <= 32'd0;
      r_mem_addr <= '0;
      r_mem_data <= 32'd0;
    end else begin
      case (r_state)
        S_HDR_LO: begin
          if (w_accept) r_cnt_lo <= in_data;
        end
        S_HDR_HI: begin
          if (w_accept) r_n <= w_hdr_n;
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm  <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
            // Load the write registers as the 4th byte lands so they are
            // already valid during the WRITE cycle and hold afterwards.
            if (r_bcnt == 2'd3) begin
              r_mem_addr <= r_idx[ADDR_WIDTH-1:0];
              r_mem_data <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_idx <= w_idx_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Expected memory writes are
//            queued when a stream is driven and popped by a monitor whenever
//            the loader strobes mem_wren.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW = 12;
  localparam int MW = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [63:0]   sb[$];
  int            cyc      = 0;
  int            wr_count = 0;
  int            last_wr  = -1;
  int            done_cyc = -1;
  int            acc_cyc  = -1;
  logic          prev_wren = 1'b0;

  always #5 clock = ~clock;

  imem_loader #(
    .ADDR_WIDTH (AW),
    .MAX_WORDS  (MW)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (mem_wren === 1'b1) begin
      wr_count++;
      last_wr = cyc;
      chk("wren_1cyc", 64'(prev_wren), 64'd0);
      chk("wr_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        chk("wr_addr_data", {32'(mem_addr), mem_data}, sb.pop_front());
      end
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    prev_wren = mem_wren;
  end

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_flags", 64'({in_ready, mem_wren, cpu_reset, done, error}), 64'b10100);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    @(negedge clock);
    #1;
    reset    = 1'b0;
    done_cyc = -1;
    wr_count = 0;
    last_wr  = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      @(negedge clock);
      #1;
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], $urandom_range(maxgap, 0));
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic two_word_stream(input int maxgap);
    send_byte(8'h02, $urandom_range(maxgap, 0));
    send_byte(8'h00, $urandom_range(maxgap, 0));
    send_word(32'h12345678, maxgap);
    send_word(32'hDEADBEEF, maxgap);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Two words, no gaps
    do_reset();
    sb.push_back({32'd0, 32'h12345678});
    sb.push_back({32'd1, 32'hDEADBEEF});
    two_word_stream(0);
    wait_done("t1_done");
    chk("t1_done_lat", 64'(done_cyc - last_wr), 64'd1);
    chk("t1_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("t1_hold", {32'(mem_addr), mem_data}, {32'd1, 32'hDEADBEEF});
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) begin
      @(negedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("t1_ignore", 64'({done, in_ready, error}), 64'b100);
    chk("t1_writes", 64'(wr_count), 64'd2);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-length image
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t2_done_next", 64'({done, cpu_reset}), 64'b10);
    chk("t2_done_cyc", 64'(done_cyc), 64'(acc_cyc));
    repeat (4) begin
      @(negedge clock);
      #1;
    end
    chk("t2_writes", 64'(wr_count), 64'd0);

    // Oversize header (N = 0x1001)
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    chk("t3_flags", 64'({error, in_ready, cpu_reset, done}), 64'b1010);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (8) begin
      @(negedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("t3_flags_after", 64'({error, in_ready, cpu_reset, done}), 64'b1010);
    chk("t3_writes", 64'(wr_count), 64'd0);

    // Same two-word stream with random valid gaps
    do_reset();
    sb.push_back({32'd0, 32'h12345678});
    sb.push_back({32'd1, 32'hDEADBEEF});
    two_word_stream(3);
    wait_done("t4_done");
    chk("t4_writes", 64'(wr_count), 64'd2);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Reset after the 2nd data byte, then full replay
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    do_reset();
    sb.push_back({32'd0, 32'h12345678});
    sb.push_back({32'd1, 32'hDEADBEEF});
    two_word_stream(0);
    wait_done("t5_done");
    chk("t5_writes", 64'(wr_count), 64'd2);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Full-size image, word k = k
    do_reset();
    for (int k = 0; k < MW; k++) sb.push_back({32'(k), 32'(k)});
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    for (int k = 0; k < MW; k++) send_word(32'(k), 0);
    wait_done("t6_done");
    chk("t6_writes", 64'(wr_count), 64'(MW));
    chk("t6_last", {32'(mem_addr), mem_data}, {32'h0000_0FFF, 32'h0000_0FFF});
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    chk("t6_cpu_reset", 64'(cpu_reset), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the memory word-address width.
REQ-002 The block SHALL have parameter MAX_WORDS, default 4096, giving the largest legal image length in words.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data holds a byte.
REQ-006 The block SHALL have port in_data, input, 8 bits: the image byte stream.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port mem_wren, output, 1 bit: instruction-memory write strobe.
REQ-009 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: instruction-memory word address.
REQ-010 The block SHALL have port mem_data, output, 32 bits: instruction-memory write data.
REQ-011 The block SHALL have port cpu_reset, output, 1 bit: holds the processor in reset until the load completes.
REQ-012 The block SHALL have port done, output, 1 bit: load completed successfully.
REQ-013 The block SHALL have port error, output, 1 bit: header rejected.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-015 The stream format SHALL be a 2-byte little-endian word count N, followed by 4N data bytes, each word little-endian (first byte into bits 7:0).
REQ-016 The FSM SHALL have states HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR.
REQ-017 in_ready SHALL be 1 exactly in HDR_LO, HDR_HI and DATA.
REQ-018 HDR_LO SHALL capture the count low byte and move to HDR_HI on acceptance.
REQ-019 On acceptance in HDR_HI, the FSM SHALL go to ERR if N > MAX_WORDS, to DONE if N = 0, and otherwise to DATA.
REQ-020 DATA SHALL shift accepted bytes into a 32-bit assembly register and count them modulo 4.
REQ-021 On the 4th accepted byte, the FSM SHALL go to WRITE.
REQ-022 In WRITE, mem_wren SHALL be 1 for exactly one cycle, with mem_data equal to the assembled word and mem_addr equal to the current word index.
REQ-023 The cycle after WRITE, the word index SHALL increment, and the FSM SHALL go to DONE if the index+1 = N, else to DATA.
REQ-024 The word index SHALL never wrap; N = MAX_WORDS ends with a final write at MAX_WORDS-1.
REQ-025 Gaps in in_valid SHALL stall the FSM without changing state or data.
REQ-026 In DONE, the block SHALL drive done = 1 and cpu_reset = 0, ignore all further bytes, and remain in DONE until reset.
REQ-027 In ERR, the block SHALL drive error = 1 and keep cpu_reset = 1, and remain in ERR until reset.
REQ-028 In every state except DONE, cpu_reset SHALL be 1.
REQ-029 Outside WRITE, mem_wren SHALL be 0, and mem_addr and mem_data SHALL hold their last values.

Reset
REQ-030 While reset is 1, the block SHALL immediately force state HDR_LO, word index 0, byte count 0, and assembly register 0.
REQ-031 While reset is 1, the outputs SHALL be: in_ready 1, mem_wren 0, mem_addr 0, mem_data 0, cpu_reset 1, done 0, error 0.
REQ-032 Reset mid-load SHALL discard partial bytes and the count, SHALL NOT erase memory already written, and SHALL make the next accepted byte a new header low byte.

Verification
REQ-033 Stream 02 00 78 56 34 12 EF BE AD DE -> the bench SHALL see writes (0,0x12345678) and (1,0xDEADBEEF), each with a 1-cycle mem_wren. It SHALL then see done = 1 and cpu_reset = 0 one cycle after the second write.
REQ-034 Stream 00 00 -> the bench SHALL see done = 1 the cycle after the high byte is accepted, and no mem_wren at any point.
REQ-035 Stream 01 10 (N = 0x1001) -> the bench SHALL see error = 1, in_ready = 0, cpu_reset = 1, and no writes; further bytes SHALL be ignored.
REQ-036 The same stream as REQ-033 with random 0-3 cycle in_valid gaps -> the bench SHALL see identical writes and addresses.
REQ-037 Reset pulse after the 2nd data byte of REQ-033, then the full stream replayed -> the bench SHALL see only the writes of the replay, starting at address 0.
REQ-038 N = 4096 with data word k = k -> the bench SHALL see 4096 writes, the last at address 0xFFF with data 0x00000FFF, and no address wrap; done SHALL follow.
